// File: rtl/rice_core_bus_arbiter.sv
// rice_core_bus_arbiter: round-robin IF/LSU arbiter onto one memory bus with an in-order response ID FIFO
module rice_core_bus_arbiter #(
    parameter int XLEN            = 32,
    parameter int ADDRESS_WIDTH   = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_inst_request_valid,
    output logic                     o_inst_request_ready,
    input  logic [ADDRESS_WIDTH-1:0] i_inst_address,
    output logic                     o_inst_response_valid,
    output logic [XLEN-1:0]          o_inst_read_data,
    input  logic                     i_data_request_valid,
    output logic                     o_data_request_ready,
    input  logic [ADDRESS_WIDTH-1:0] i_data_address,
    input  logic                     i_data_write,
    input  logic [XLEN-1:0]          i_data_write_data,
    input  logic [XLEN/8-1:0]        i_data_strobe,
    output logic                     o_data_response_valid,
    output logic [XLEN-1:0]          o_data_read_data,
    output logic                     o_mem_request_valid,
    input  logic                     i_mem_request_ready,
    output logic [ADDRESS_WIDTH-1:0] o_mem_address,
    output logic                     o_mem_write,
    output logic [XLEN-1:0]          o_mem_write_data,
    output logic [XLEN/8-1:0]        o_mem_strobe,
    input  logic                     i_mem_response_valid,
    input  logic [XLEN-1:0]          i_mem_read_data
);
    localparam int PTR_W = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {IDLE, HOLD_INST, HOLD_DATA} state_e;

    state_e                     state_q;
    logic                       last_grant_q;
    logic [MAX_OUTSTANDING-1:0] ids_q;
    logic [PTR_W-1:0]           wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]           count_q, count_d;
    logic                       grant, granted_valid, full, accept, pop, head_id;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Grant select: a held grant is locked; otherwise sole requester, ties go to the port not served last (1 = DATA)
    always_comb begin
        grant = (state_q == HOLD_INST) ? 1'b0 :
                (state_q == HOLD_DATA) ? 1'b1 :
                (i_inst_request_valid && i_data_request_valid) ? ~last_grant_q : i_data_request_valid;
    end

    assign full          = count_q == CNT_W'(MAX_OUTSTANDING);
    assign granted_valid = grant ? i_data_request_valid : i_inst_request_valid;
    assign accept        = o_mem_request_valid && i_mem_request_ready;
    assign pop           = !i_rst && i_mem_response_valid && count_q != '0;
    assign head_id       = ids_q[rd_ptr_q];
    assign count_d       = count_q + CNT_W'(accept) - CNT_W'(pop);

    assign o_mem_request_valid   = !i_rst && granted_valid && !full;
    assign o_inst_request_ready  = !i_rst && !grant && i_mem_request_ready && !full;
    assign o_data_request_ready  = !i_rst && grant && i_mem_request_ready && !full;
    assign o_mem_address         = i_rst ? '0 : grant ? i_data_address : i_inst_address;
    assign o_mem_write           = !i_rst && grant && i_data_write;
    assign o_mem_write_data      = (i_rst || !grant) ? '0 : i_data_write_data;
    assign o_mem_strobe          = i_rst ? '0 : grant ? i_data_strobe : '1;
    assign o_inst_response_valid = pop && !head_id;
    assign o_data_response_valid = pop && head_id;
    assign o_inst_read_data      = i_rst ? '0 : i_mem_read_data;
    assign o_data_read_data      = i_rst ? '0 : i_mem_read_data;

    // Grant FSM: lock onto an offered-but-stalled request, remember the last port actually served
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b0;
        end else begin
            if (accept) last_grant_q <= grant;
            state_q <= accept ? IDLE : o_mem_request_valid ? (grant ? HOLD_DATA : HOLD_INST) : state_q;
        end
    end

    // ID FIFO: record the requester of every accepted transfer, retire one per memory response
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (accept) begin
                ids_q[wr_ptr_q] <= grant;
                wr_ptr_q        <= next_ptr(wr_ptr_q);
            end
            if (pop) rd_ptr_q <= next_ptr(rd_ptr_q);
            count_q <= count_d;
        end
    end

    // A response with nothing outstanding has no owner and is dropped
    always_ff @(posedge i_clk) begin
        if (!i_rst && i_mem_response_valid)
            assert (count_q != '0) else $warning("rice_core_bus_arbiter: stray memory response dropped");
    end
endmodule
